// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute unit: opcodes, funct3 codes and the ALU operation encoding.
package alu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_SRL    = 4'd9,
    ALU_COPY_B = 4'd10,
    ALU_XXX    = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of opcode/funct3/instruction[30] into the 4-bit ALU operation.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct,
  input  logic       add_rshift_type,
  output logic [3:0] ALUop
);

  alu_op_e op;

  always_comb begin
    op = ALU_XXX;
    case (opcode)
      OPC_LUI: op = ALU_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE: op = ALU_ADD;
      OPC_RTYPE, OPC_ITYPE: begin
        case (funct)
          // For I-type, bit 30 belongs to the immediate, so funct 000 never subtracts.
          F3_ADD_SUB: op = (opcode == OPC_RTYPE && add_rshift_type) ? ALU_SUB : ALU_ADD;
          F3_SLL:     op = ALU_SLL;
          F3_SLT:     op = ALU_SLT;
          F3_SLTU:    op = ALU_SLTU;
          F3_XOR:     op = ALU_XOR;
          F3_SRL_SRA: op = add_rshift_type ? ALU_SRA : ALU_SRL;
          F3_OR:      op = ALU_OR;
          F3_AND:     op = ALU_AND;
          default:    op = ALU_XXX;
        endcase
      end
      default: op = ALU_XXX;
    endcase
  end

  assign ALUop = op;

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: combinational decode and result, plus a one-cycle registered copy with valid.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct,
  input  logic             add_rshift_type,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] OutQ,
  output logic             OutQ_valid
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [4:0]       shamt;
  logic        [WIDTH-1:0] out_p0;
  logic        [WIDTH-1:0] out_p1;
  logic                    vld_p1;

  alu_op_decoder u_dec (
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .ALUop           (ALUop)
  );

  assign a_s   = A;
  assign b_s   = B;
  assign shamt = B[4:0];

  // Stage p0: combinational datapath
  always_comb begin
    out_p0 = '0;
    case (alu_op_e'(ALUop))
      ALU_ADD:    out_p0 = A + B;
      ALU_SUB:    out_p0 = A - B;
      ALU_AND:    out_p0 = A & B;
      ALU_OR:     out_p0 = A | B;
      ALU_XOR:    out_p0 = A ^ B;
      ALU_SLT:    out_p0 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:   out_p0 = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLL:    out_p0 = A << shamt;
      ALU_SRA:    out_p0 = a_s >>> shamt;
      ALU_SRL:    out_p0 = A >> shamt;
      ALU_COPY_B: out_p0 = B;
      default:    out_p0 = '0;
    endcase
  end

  assign Out = out_p0;

  // Stage p1: result register; captured every cycle, consumers qualify with valid
  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      out_p1 <= out_p0;
      vld_p1 <= in_valid;
    end
  end

  assign OutQ       = out_p1;
  assign OutQ_valid = vld_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against an independent decode/ALU reference model.
module tb_alu_exec_unit;

  logic        Clock = 1'b0;
  logic        Rst_n = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct = '0;
  logic        add_rshift_type = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [31:0] OutQ;
  logic        OutQ_valid;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        vld;
  } exp_t;
  exp_t sb[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .Clock           (Clock),
    .Rst_n           (Rst_n),
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .A               (A),
    .B               (B),
    .in_valid        (in_valid),
    .ALUop           (ALUop),
    .Out             (Out),
    .OutQ            (OutQ),
    .OutQ_valid      (OutQ_valid)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] model_dec(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
    logic [3:0] r;
    r = 4'd15;
    if (opc == 7'b0110111) r = 4'd10;
    else if (opc == 7'b0010111 || opc == 7'b1101111 || opc == 7'b1100111 ||
             opc == 7'b1100011 || opc == 7'b0000011 || opc == 7'b0100011) r = 4'd0;
    else if (opc == 7'b0110011 || opc == 7'b0010011) begin
      case (f3)
        3'd0: r = (opc == 7'b0110011 && b30) ? 4'd1 : 4'd0;
        3'd1: r = 4'd7;
        3'd2: r = 4'd5;
        3'd3: r = 4'd6;
        3'd4: r = 4'd4;
        3'd5: r = b30 ? 4'd8 : 4'd9;
        3'd6: r = 4'd3;
        default: r = 4'd2;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    r  = 32'h0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + ~b + 32'd1;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
      4'd6:  r = {31'b0, (a < b)};
      4'd7:  r = a << sh;
      4'd8:  begin ext = {{32{a[31]}}, a}; ext = ext >> sh; r = ext[31:0]; end
      4'd9:  r = a >> sh;
      4'd10: r = b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic step(input string tag, input logic [6:0] opc, input logic [2:0] f3, input logic b30,
                      input logic [31:0] a, input logic [31:0] b, input logic iv,
                      input logic [3:0] eop, input logic [31:0] eout);
    exp_t e;
    opcode = opc; funct = f3; add_rshift_type = b30; A = a; B = b; in_valid = iv;
    #1;
    check({tag, "/op"}, {28'b0, ALUop}, {28'b0, eop});
    check({tag, "/out"}, Out, eout);
    sb.push_back('{res: eout, vld: iv});
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    check({tag, "/q"}, OutQ, e.res);
    check({tag, "/qv"}, {31'b0, OutQ_valid}, {31'b0, e.vld});
  endtask

  initial begin
    logic [6:0]  ropc;
    logic [2:0]  rf3;
    logic        rb30;
    logic [31:0] ra, rb;
    logic [3:0]  eop;

    // Reset state, then deassert mid-cycle
    #2 Rst_n = 1'b0;
    #1;
    check("rst_q", OutQ, 32'h0);
    check("rst_qv", {31'b0, OutQ_valid}, 32'h0);
    @(posedge Clock); #1;
    check("rst_hold_q", OutQ, 32'h0);
    check("rst_hold_qv", {31'b0, OutQ_valid}, 32'h0);
    Rst_n = 1'b1;

    // Non-ALU opcodes
    step("lui",    7'b0110111, 3'd5, 1'b1, 32'h80000005, 32'hFFFF8003, 1'b1, 4'd10, 32'hFFFF8003);
    step("auipc",  7'b0010111, 3'd3, 1'b1, 32'h80000005, 32'hFFFF8003, 1'b1, 4'd0,  32'h7FFF8008);
    step("branch", 7'b1100011, 3'd1, 1'b0, 32'h80000005, 32'hFFFF8003, 1'b1, 4'd0,  32'h7FFF8008);
    step("load",   7'b0000011, 3'd2, 1'b1, 32'h80000005, 32'hFFFF8003, 1'b1, 4'd0,  32'h7FFF8008);
    step("store",  7'b0100011, 3'd0, 1'b1, 32'h80000005, 32'hFFFF8003, 1'b1, 4'd0,  32'h7FFF8008);
    step("jal",    7'b1101111, 3'd7, 1'b1, 32'h80000005, 32'hFFFF8003, 1'b1, 4'd0,  32'h7FFF8008);
    step("jalr",   7'b1100111, 3'd0, 1'b0, 32'h80000005, 32'hFFFF8003, 1'b1, 4'd0,  32'h7FFF8008);

    // R-type arithmetic/logic
    step("r_add", 7'b0110011, 3'd0, 1'b0, 32'hA, 32'h3, 1'b1, 4'd0, 32'hD);
    step("r_sub", 7'b0110011, 3'd0, 1'b1, 32'hA, 32'h3, 1'b1, 4'd1, 32'h7);
    step("r_and", 7'b0110011, 3'd7, 1'b0, 32'hA, 32'h3, 1'b1, 4'd2, 32'h2);
    step("r_or",  7'b0110011, 3'd6, 1'b0, 32'hA, 32'h3, 1'b1, 4'd3, 32'hB);
    step("r_xor", 7'b0110011, 3'd4, 1'b0, 32'hA, 32'h3, 1'b0, 4'd4, 32'h9);

    // Shifts use only B[4:0]
    step("sll",   7'b0110011, 3'd1, 1'b0, 32'h80000010, 32'h24, 1'b1, 4'd7, 32'h00000100);
    step("srl",   7'b0110011, 3'd5, 1'b0, 32'h80000010, 32'h24, 1'b1, 4'd9, 32'h08000001);
    step("sra",   7'b0110011, 3'd5, 1'b1, 32'h80000010, 32'h24, 1'b1, 4'd8, 32'hF8000001);
    step("i_add", 7'b0010011, 3'd0, 1'b1, 32'h80000010, 32'h24, 1'b1, 4'd0, 32'h80000034);
    step("sll0",  7'b0110011, 3'd1, 1'b0, 32'h12345678, 32'hFFFFFFE0, 1'b1, 4'd7, 32'h12345678);
    step("sra31", 7'b0010011, 3'd5, 1'b1, 32'h80000000, 32'h1F, 1'b1, 4'd8, 32'hFFFFFFFF);

    // Compares and undefined opcode
    step("slt",     7'b0110011, 3'd2, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, 4'd5, 32'h1);
    step("sltu",    7'b0110011, 3'd3, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, 4'd6, 32'h0);
    step("slt_min", 7'b0110011, 3'd2, 1'b0, 32'h80000000, 32'h1, 1'b1, 4'd5, 32'h1);
    step("sltu_min",7'b0010011, 3'd3, 1'b0, 32'h80000000, 32'h1, 1'b1, 4'd6, 32'h0);
    step("undef",   7'b1111111, 3'd2, 1'b1, 32'hDEADBEEF, 32'h1234, 1'b1, 4'd15, 32'h0);

    // Registered path and asynchronous reset between edges
    step("q_add", 7'b0110011, 3'd0, 1'b0, 32'h2, 32'h3, 1'b1, 4'd0, 32'h5);
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_q", OutQ, 32'h0);
    check("async_rst_qv", {31'b0, OutQ_valid}, 32'h0);
    Rst_n = 1'b1;
    step("post_rst", 7'b0110011, 3'd0, 1'b0, 32'h7, 32'h8, 1'b1, 4'd0, 32'hF);

    // Random regression over R/I funct combinations; stops at first mismatch
    for (int i = 0; i < 40; i++) begin
      ropc = $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
      rf3  = 3'($urandom_range(0, 7));
      rb30 = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      if (i % 8 == 0) ra = {1'b1, ra[30:0]};
      eop  = model_dec(ropc, rf3, rb30);
      step($sformatf("rnd%0d", i), ropc, rf3, rb30, ra, rb, 1'($urandom_range(0, 1)),
           eop, model_alu(eop, ra, rb));
      if (errors != 0) break;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
